// File: rtl/gate_pair_checker.sv
// gate_pair_checker
// -----------------------------------------------------------------------------
// Self-checking consumer placed directly after the two-output gate pair
// (a = ~x & y, b = ~(x ^ y)). It accepts one {x, y, a, b} sample per
// valid/ready handshake, recomputes the expected gate outputs, counts samples
// and mismatches, records which {x,y} input combinations were exercised, and
// at the end of a run reports pass/fail together with the first failing sample.
//
// Ports
//   clk              in   single clock, all state updates on the rising edge
//   rst              in   synchronous active-high reset (highest priority)
//   start            in   one-cycle pulse, begins or restarts a run
//   in_valid         in   sample present on x, y, a, b
//   in_ready         out  checker accepts a sample this cycle
//   x, y             in   stimulus driven into the gate pair
//   a, b             in   gate-pair outputs under check
//   busy             out  run in progress
//   done             out  run complete, held until start or rst
//   pass             out  no mismatches and full coverage (valid while done=1)
//   sample_count     out  samples accepted this run
//   err_count        out  mismatching samples this run
//   coverage         out  bit {x,y} set once that combination was accepted
//   first_err_valid  out  at least one mismatch has been captured
//   first_err_vec    out  {x,y,a,b} of the first mismatching sample
// -----------------------------------------------------------------------------
module gate_pair_checker #(
    parameter int N_SAMPLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             x,
    input  logic             y,
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       coverage,
    output logic             first_err_valid,
    output logic [3:0]       first_err_vec
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] L_N_SAMPLES = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] L_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    // Reference model of the gate pair: 1 when the observed outputs disagree.
    function automatic logic gate_mismatch(input logic fx, input logic fy,
                                           input logic fa, input logic fb);
        logic ea;
        logic eb;
        ea = ~fx & fy;
        eb = ~(fx ^ fy);
        return (fa != ea) | (fb != eb);
    endfunction

    state_t           r_state;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_sample_count;
    logic [CNT_W-1:0] r_err_count;
    logic [3:0]       r_coverage;
    logic             r_first_err_valid;
    logic [3:0]       r_first_err_vec;

    logic             w_accept;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_err_next;
    logic [3:0]       w_cov_next;

    // start in the same cycle wins over the sample, which is then discarded.
    assign w_accept   = (r_state == ST_RUN) & r_in_ready & in_valid & ~start;
    assign w_mismatch = gate_mismatch(x, y, a, b);
    assign w_cnt_next = r_sample_count + L_ONE;
    assign w_err_next = w_mismatch ? (r_err_count + L_ONE) : r_err_count;
    assign w_cov_next = r_coverage | (4'b0001 << {x, y});

    // Run-control FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_in_ready        <= 1'b0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_sample_count    <= '0;
            r_err_count       <= '0;
            r_coverage        <= 4'b0000;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= 4'b0000;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN, ST_DONE: begin
                    if (start) begin
                        // Begin or restart: wipe all run status.
                        r_state           <= ST_RUN;
                        r_in_ready        <= 1'b1;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                        r_sample_count    <= '0;
                        r_err_count       <= '0;
                        r_coverage        <= 4'b0000;
                        r_first_err_valid <= 1'b0;
                        r_first_err_vec   <= 4'b0000;
                    end else if (w_accept) begin
                        r_sample_count <= w_cnt_next;
                        r_err_count    <= w_err_next;
                        r_coverage     <= w_cov_next;
                        if (w_mismatch && !r_first_err_valid) begin
                            r_first_err_valid <= 1'b1;
                            r_first_err_vec   <= {x, y, a, b};
                        end else begin
                            r_first_err_valid <= r_first_err_valid;
                            r_first_err_vec   <= r_first_err_vec;
                        end
                        if (w_cnt_next == L_N_SAMPLES) begin
                            // pass uses the post-update counters of the last sample.
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_pass     <= (w_err_next == '0) & (w_cov_next == 4'hF);
                        end else begin
                            r_state    <= r_state;
                            r_in_ready <= r_in_ready;
                            r_busy     <= r_busy;
                            r_done     <= r_done;
                            r_pass     <= r_pass;
                        end
                    end else begin
                        // No start, no handshake: hold everything.
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state           <= ST_IDLE;
                    r_in_ready        <= 1'b0;
                    r_busy            <= 1'b0;
                    r_done            <= 1'b0;
                    r_pass            <= 1'b0;
                    r_sample_count    <= '0;
                    r_err_count       <= '0;
                    r_coverage        <= 4'b0000;
                    r_first_err_valid <= 1'b0;
                    r_first_err_vec   <= 4'b0000;
                end
            endcase
        end
    end

    assign in_ready        = r_in_ready;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign sample_count    = r_sample_count;
    assign err_count       = r_err_count;
    assign coverage        = r_coverage;
    assign first_err_valid = r_first_err_valid;
    assign first_err_vec   = r_first_err_vec;

endmodule

// File: doc/gate_pair_checker.md
# gate_pair_checker

Self-checking consumer that sits directly downstream of the two-output gate pair (a = ~x & y, b = ~(x ^ y)). Accepts one {x, y, a, b} sample per valid/ready handshake. Recomputes the expected a and b, counts samples and mismatches, and records which of the four input combinations were exercised. At the end of a run it reports pass/fail and captures the first failing sample.

## Interface
- N_SAMPLES, 4: samples per run; legal range 1 .. 2^CNT_W-1.
- CNT_W, 8: width of the sample and error counters.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins (or restarts) a run.
- in_valid  in  1  sample present on x, y, a, b.
- in_ready  out  1  checker accepts a sample this cycle.
- x, y  in  1 each  stimulus driven into the gate pair.
- a, b  in  1 each  gate-pair outputs under check.
- busy  out  1  run in progress.
- done  out  1  run complete; held until start or rst.
- pass  out  1  valid only while done=1.
- sample_count  out  CNT_W  samples accepted this run.
- err_count  out  CNT_W  mismatching samples this run.
- coverage  out  4  bit {x,y} set once that combination has been accepted.
- first_err_valid  out  1  at least one mismatch has been captured.
- first_err_vec  out  4  {x,y,a,b} of the first mismatching sample.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: every output is 0. This includes in_ready, busy, done, pass, both counters, coverage, first_err_valid and first_err_vec.
- IDLE: in_ready=0 and busy=0. in_valid is ignored. start moves the FSM to RUN.
- RUN: in_ready=1 and busy=1. A sample is accepted when in_valid & in_ready & ~start.
- Expected values:
  - ea = ~x & y
  - eb = ~(x ^ y)
  - Mismatch when (a != ea) | (b != eb).
- On each accepted sample:
  - sample_count increments by 1.
  - coverage[{x,y}] is set to 1.
  - On a mismatch, err_count increments by 1.
  - On a mismatch with first_err_valid=0, first_err_vec is loaded with {x,y,a,b} and first_err_valid is set to 1.
- Counters cannot overflow because N_SAMPLES ≤ 2^CNT_W-1. No saturation logic is provided.
- RUN → DONE on the accepted sample that brings sample_count to N_SAMPLES.
- DONE:
  - done=1, busy=0, in_ready=0.
  - pass = (err_count==0) & (coverage==4'hF).
  - All status outputs are held.
- start in RUN or DONE:
  - Clears sample_count, err_count, coverage, first_err_valid, first_err_vec, done and pass.
  - Next state is RUN.
  - Any sample presented in the same cycle is discarded.
- rst has priority over start and over sample acceptance.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Counters, coverage and first-error capture update on the edge that accepts the sample, so they are visible in the following cycle.
- done and pass assert in the cycle after the final handshake. in_ready drops in that same cycle.
- Back-to-back acceptance: one sample per cycle while in_valid=1.
- Gaps in in_valid stall the run without changing any state.
- start takes effect on the next edge: busy=1 and in_ready=1 in the following cycle.
- rst asserted mid-run returns the block to IDLE with all outputs 0 on the next edge.

## Test plan
- Correct run, N_SAMPLES=4. After rst, pulse start, then feed {x,y,a,b} = 0001, 0110, 1000, 1101 on consecutive cycles. Required: done=1 the cycle after the 4th sample; pass=1; err_count=0; sample_count=4; coverage=4'hF; first_err_valid=0.
- Single fault. Same run, but the third sample is {x,y,a,b}=1010. Required: err_count=1; first_err_valid=1; first_err_vec=4'b1010; coverage=4'hF; pass=0.
- Coverage hole. Feed 0001 four times, all correct. Required: err_count=0; coverage=4'b0001; pass=0.
- Handshake gaps. Toggle in_valid 1,0,0,1,1,0,1 while feeding correct samples, with in_valid also pulsed in IDLE before start. Required: only valid cycles in RUN are counted; done=1 exactly after the 4th accepted sample; the IDLE pulses have no effect.
- Restart mid-run. Accept 2 samples, then assert start with in_valid=1 and a faulty sample. Required: the next cycle shows sample_count=0, err_count=0, coverage=0, busy=1; 4 further samples are needed to reach done.
- Reset mid-run. Accept 3 samples including one fault, then assert rst for one cycle. Required: the next cycle shows every output 0 and state IDLE; in_valid is ignored until start.
